// File: rtl/binary_to_bcd.sv
// 5-bit binary to two BCD digits via a free-running double-dabble engine. Fixed 7-cycle period.
// Outputs are registered and change only on the UPDATE edge. There is no backpressure.
module binary_to_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Nb,
  output logic [3:0] Decenas,
  output logic [3:0] Unidades,
  output logic       done
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]  r_state;
  logic [12:0] r_work;
  logic [2:0]  r_cnt;
  logic [3:0]  r_dec;
  logic [3:0]  r_uni;
  logic        r_done;

  logic [3:0]  w_tens_adj;
  logic [3:0]  w_ones_adj;
  logic [12:0] w_shifted;

  // Each digit is corrected before the shift so it cannot exceed 9 once doubled.
  always_comb begin
    w_tens_adj = (r_work[12:9] >= 4'd5) ? r_work[12:9] + 4'd3 : r_work[12:9];
    w_ones_adj = (r_work[8:5]  >= 4'd5) ? r_work[8:5]  + 4'd3 : r_work[8:5];
    w_shifted  = {w_tens_adj[2:0], w_ones_adj, r_work[4:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_work  <= '0;
      r_cnt   <= '0;
      r_dec   <= '0;
      r_uni   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_work  <= {8'd0, Nb};
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt + 3'd1;
          if (r_cnt == 3'd4) begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_dec   <= r_work[12:9];
          r_uni   <= r_work[8:5];
          r_done  <= 1'b1;
          r_state <= S_LOAD;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign Decenas  = r_dec;
  assign Unidades = r_uni;
  assign done     = r_done;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: a timing model scoreboards every cycle, plus a vector table and corner sequences.
module tb_binary_to_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Nb;
  logic [3:0] Decenas;
  logic [3:0] Unidades;
  logic       done;

  always #5 clk = ~clk;

  binary_to_bcd dut (
    .clk      (clk),
    .reset    (reset),
    .Nb       (Nb),
    .Decenas  (Decenas),
    .Unidades (Unidades),
    .done     (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] u;
  } res_t;

  res_t       sb_q[$];
  int         phase     = 0;
  logic [3:0] exp_dec   = 4'd0;
  logic [3:0] exp_uni   = 4'd0;
  logic       exp_done  = 1'b0;
  bit         started   = 1'b0;

  // Reference timing: LOAD on phase 0, results land on the 7th edge of each conversion.
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      phase    = 0;
      exp_dec  = 4'd0;
      exp_uni  = 4'd0;
      exp_done = 1'b0;
      sb_q.delete();
    end else begin
      exp_done = (phase == 6);
      if (phase == 0) sb_q.push_back('{d: 4'(Nb / 10), u: 4'(Nb % 10)});
      if (phase == 6 && sb_q.size() > 0) begin
        res_t r;
        r = sb_q.pop_front();
        exp_dec = r.d;
        exp_uni = r.u;
      end
      phase = (phase + 1) % 7;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("done", 32'(done), 32'(exp_done));
      chk("tens", 32'(Decenas), 32'(exp_dec));
      chk("units", 32'(Unidades), 32'(exp_uni));
      if (done === 1'b1) begin
        chk("tens_valid_bcd", 32'(Decenas <= 4'd3), 32'd1);
        chk("units_valid_bcd", 32'(Unidades <= 4'd9), 32'd1);
      end
    end
  end

  typedef struct {
    logic [4:0] nb;
    logic [3:0] d;
    logic [3:0] u;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done pulse within 20 cycles (t=%0t)", $time);
    end
  endtask

  task automatic count_to_done(input string name);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen ? n : 0), 32'd7);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (phase == p) break;
    end
    chk("phase_align", 32'(phase), 32'(p));
  endtask

  initial begin
    tbl[0] = '{nb: 5'd31, d: 4'd3, u: 4'd1};
    tbl[1] = '{nb: 5'd21, d: 4'd2, u: 4'd1};
    tbl[2] = '{nb: 5'd24, d: 4'd2, u: 4'd4};
    tbl[3] = '{nb: 5'd9,  d: 4'd0, u: 4'd9};
    tbl[4] = '{nb: 5'd10, d: 4'd1, u: 4'd0};
    tbl[5] = '{nb: 5'd0,  d: 4'd0, u: 4'd0};

    reset = 1'b1;
    Nb    = 5'b11111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_to_done("first_done_edges");
    chk("first_tens", 32'(Decenas), 32'd3);
    chk("first_units", 32'(Unidades), 32'd1);

    for (int i = 0; i < 6; i++) begin
      Nb = tbl[i].nb;
      wait_done();
      wait_done();
      chk("vec_tens", 32'(Decenas), 32'(tbl[i].d));
      chk("vec_units", 32'(Unidades), 32'(tbl[i].u));
      @(negedge clk);
    end

    for (int v = 0; v < 32; v++) begin
      Nb = 5'(v);
      wait_done();
      wait_done();
      chk("sweep_sum", 32'(Decenas) * 10 + 32'(Unidades), 32'(v));
      @(negedge clk);
    end

    Nb = 5'd13;
    wait_done();
    wait_done();
    wait_phase(2);
    Nb = 5'd28;
    wait_done();
    chk("late_change_tens", 32'(Decenas), 32'd1);
    chk("late_change_units", 32'(Unidades), 32'd3);
    wait_done();
    chk("after_change_tens", 32'(Decenas), 32'd2);
    chk("after_change_units", 32'(Unidades), 32'd8);

    Nb = 5'd27;
    wait_done();
    wait_done();
    wait_phase(3);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tens", 32'(Decenas), 32'd0);
    chk("abort_units", 32'(Unidades), 32'd0);
    reset = 1'b0;
    count_to_done("restart_done_edges");
    chk("restart_tens", 32'(Decenas), 32'd2);
    chk("restart_units", 32'(Unidades), 32'd7);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
